// File: rtl/phys_pkg.sv
// Constants and types shared between the collision pair scheduler and the physics engine.
package phys_pkg;
  localparam int DF_TIME_W    = 32;  // DF fixed-point time width
  localparam int DF_FRAC_W    = 11;  // fractional bits of DF time
  localparam int DF_OBJ_COUNT = 8;
  localparam int DF_IDX_W     = $clog2(DF_OBJ_COUNT);

  typedef logic [DF_IDX_W-1:0] obj_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;
endpackage

// File: rtl/collision_pair_scheduler_if.sv
// Pair-issue and result-return handshake between the scheduler and the collision checker.
interface collision_pair_scheduler_if #(
  parameter int IDX_W  = phys_pkg::DF_IDX_W,
  parameter int TIME_W = phys_pkg::DF_TIME_W
);
  logic              pair_valid_out;
  logic              pair_ready_in;
  logic [IDX_W-1:0]  pair_i_out;
  logic [IDX_W-1:0]  pair_j_out;
  logic              res_valid_in;
  logic              res_hit_in;
  logic [TIME_W-1:0] res_time_in;

  // scheduler side
  modport master (
    output pair_valid_out, pair_i_out, pair_j_out,
    input  pair_ready_in, res_valid_in, res_hit_in, res_time_in
  );

  // checker side
  modport slave (
    input  pair_valid_out, pair_i_out, pair_j_out,
    output pair_ready_in, res_valid_in, res_hit_in, res_time_in
  );
endinterface

// File: rtl/pair_fifo.sv
// Small synchronous FIFO holding the {i,j} of pairs awaiting a checker result.
module pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // storage write; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // pointers wrap explicitly so DEPTH need not fill the pointer range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/collision_pair_scheduler.sv
// Walks all unordered object pairs, issues non-static pairs to the collision checker and
// keeps the earliest qualifying hit as the pass result.
module collision_pair_scheduler
  import phys_pkg::*;
#(
  parameter int OBJ_COUNT       = 8,
  parameter int IDX_W           = $clog2(OBJ_COUNT),
  parameter int TIME_W          = DF_TIME_W,
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start_in,
  input  logic [OBJ_COUNT-1:0] static_mask_in,
  input  logic [TIME_W-1:0]    left_time_in,
  collision_pair_scheduler_if.master chk,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 coll_found_out,
  output logic [TIME_W-1:0]    coll_time_out,
  output logic [IDX_W-1:0]     coll_i_out,
  output logic [IDX_W-1:0]     coll_j_out,
  output logic                 err_out
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(OBJ_COUNT - 2);
  localparam logic [IDX_W-1:0] LAST_J  = IDX_W'(OBJ_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]           state;
  logic [OBJ_COUNT-1:0] mask;
  logic [TIME_W-1:0]    best_time;
  logic [IDX_W-1:0]     pi, pj, ci, cj;
  logic [CNT_W-1:0]     cnt;
  logic                 found, err;
  logic                 fifo_full, fifo_empty;
  logic [2*IDX_W-1:0]   head;
  logic                 skip, issue, advance, last_pair, res_acc, qual, accept_start, drained;

  // pair is offered only while the FIFO (== outstanding count) has room
  assign chk.pair_valid_out = (state == ST_ISSUE) && !skip && !fifo_full;
  assign chk.pair_i_out     = pi;
  assign chk.pair_j_out     = pj;

  assign busy_out       = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done_out       = (state == ST_DONE);
  assign coll_found_out = found;
  assign coll_time_out  = best_time;
  assign coll_i_out     = ci;
  assign coll_j_out     = cj;
  assign err_out        = err;

  // per-cycle decode of generator advance and result acceptance
  always_comb begin
    accept_start = (state == ST_IDLE) && start_in;
    skip         = mask[pi] && mask[pj];
    issue        = chk.pair_valid_out && chk.pair_ready_in;
    advance      = (state == ST_ISSUE) && (skip || issue);
    last_pair    = (pi == LAST_I) && (pj == LAST_J);
    res_acc      = chk.res_valid_in && ((state == ST_ISSUE) || (state == ST_DRAIN)) && !fifo_empty;
    qual         = res_acc && chk.res_hit_in && (chk.res_time_in < best_time);
    // outstanding reaches zero at the coming edge
    drained      = (cnt == '0) || ((cnt == CNT_ONE) && res_acc);
  end

  pair_fifo #(.DEPTH(MAX_OUTSTANDING), .W(2*IDX_W)) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (issue),
    .pop   (res_acc),
    .wdata ({pi, pj}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // pass sequencing
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (start_in) state <= ST_ISSUE;
        ST_ISSUE: if (advance && last_pair) state <= ST_DRAIN;
        ST_DRAIN: if (drained) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // issued-but-unanswered count; simultaneous issue and result cancel
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt <= '0;
    else begin
      case ({issue, res_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // pair generator and running best hit; strict < keeps the earlier pair on ties
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mask      <= '0;
      best_time <= '0;
      found     <= 1'b0;
      ci        <= '0;
      cj        <= '0;
      pi        <= '0;
      pj        <= '0;
    end else if (accept_start) begin
      mask      <= static_mask_in;
      best_time <= left_time_in;
      found     <= 1'b0;
      ci        <= '0;
      cj        <= '0;
      pi        <= '0;
      pj        <= IDX_W'(1);
    end else begin
      if (advance && !last_pair) begin
        if (pj == LAST_J) begin
          pi <= pi + 1'b1;
          pj <= pi + IDX_W'(2);
        end else begin
          pj <= pj + 1'b1;
        end
      end
      if (qual) begin
        best_time <= chk.res_time_in;
        found     <= 1'b1;
        ci        <= head[2*IDX_W-1:IDX_W];
        cj        <= head[IDX_W-1:0];
      end
    end
  end

  // sticky error for results nobody asked for; a new pass clears it
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) err <= 1'b0;
    else if (chk.res_valid_in && !res_acc) err <= 1'b1;
    else if (accept_start) err <= 1'b0;
  end
endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Randomized bench for collision_pair_scheduler with a pair-list / earliest-hit reference model.
module tb_collision_pair_scheduler;
  import phys_pkg::*;

  localparam int N    = 8;
  localparam int IW   = 3;
  localparam int TW   = 32;
  localparam int MAXO = 4;
  localparam int NP   = N*(N-1)/2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          start_in;
  logic [N-1:0]  static_mask_in;
  logic [TW-1:0] left_time_in;
  logic          busy_out, done_out, coll_found_out, err_out;
  logic [TW-1:0] coll_time_out;
  logic [IW-1:0] coll_i_out, coll_j_out;

  collision_pair_scheduler_if #(.IDX_W(IW), .TIME_W(TW)) chk();

  collision_pair_scheduler #(.OBJ_COUNT(N), .IDX_W(IW), .TIME_W(TW), .MAX_OUTSTANDING(MAXO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_in(start_in),
    .static_mask_in(static_mask_in), .left_time_in(left_time_in), .chk(chk),
    .busy_out(busy_out), .done_out(done_out), .coll_found_out(coll_found_out),
    .coll_time_out(coll_time_out), .coll_i_out(coll_i_out), .coll_j_out(coll_j_out),
    .err_out(err_out)
  );

  always #5 sys_clk = ~sys_clk;

  int total, bad;

  // checker model contents
  bit            hit_en [N][N];
  logic [TW-1:0] hit_t  [N][N];

  // observations from the last pass
  logic [8*NP-1:0] iss_vec;
  int              iss_n, n_done, done_cyc, busy_bad, stab_bad, over_bad, max_out;
  bit              timed_out;
  logic [48:0]     abort_snap;

  // reference model results
  logic [8*NP-1:0] exp_vec;
  int              exp_n;
  logic [39:0]     exp_res;

  function automatic logic [48:0] out_snap();
    return {busy_out, done_out, coll_found_out, coll_time_out, coll_i_out, coll_j_out, err_out,
            chk.pair_valid_out, chk.pair_i_out, chk.pair_j_out};
  endfunction

  function automatic logic [39:0] res_obs();
    return {coll_found_out, coll_time_out, coll_i_out, coll_j_out, err_out};
  endfunction

  task automatic clear_hits();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        hit_en[i][j] = 1'b0;
        hit_t[i][j]  = '0;
      end
  endtask

  // expected issue list and earliest strictly-smaller hit, walking pairs in order
  task automatic ref_model(input logic [N-1:0] mask, input logic [TW-1:0] lt);
    logic [TW-1:0] best;
    best = lt; exp_vec = '0; exp_n = 0;
    exp_res = {1'b0, lt, 3'd0, 3'd0, 1'b0};
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (!(mask[i] && mask[j])) begin
          exp_vec = {exp_vec[8*NP-9:0], 8'((i << 4) | j)};
          exp_n++;
          if (hit_en[i][j] && hit_t[i][j] < best) begin
            best    = hit_t[i][j];
            exp_res = {1'b1, best, 3'(i), 3'(j), 1'b0};
          end
        end
  endtask

  // drives one pass acting as the checker; c counts negedges after the start edge
  task automatic run_pass(input logic [N-1:0] mask, input logic [TW-1:0] lt, input int lat,
                          input int rdy_pct, input int restart_at, input bit abort_drain);
    int pq_i[$], pq_j[$], pq_due[$];
    int outst, hi, hj, ri, rj;
    bit hold, rdy;
    iss_vec = '0; iss_n = 0; n_done = 0; done_cyc = -1; busy_bad = 0; stab_bad = 0;
    over_bad = 0; max_out = 0; outst = 0; hold = 0; hi = 0; hj = 0; timed_out = 1;
    @(negedge sys_clk);
    static_mask_in = mask; left_time_in = lt; start_in = 1'b1;
    @(negedge sys_clk);
    start_in = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      if (abort_drain && iss_n == NP && outst > 0) begin
        sys_rst_n = 1'b0;
        #1 abort_snap = out_snap();
        chk.res_valid_in = 1'b0; chk.pair_ready_in = 1'b0;
        repeat (4) begin
          @(negedge sys_clk);
          if (done_out) n_done++;
        end
        sys_rst_n = 1'b1;
        timed_out = 0;
        break;
      end
      if (done_out) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        if (busy_out) busy_bad++;
      end else if (done_cyc < 0 && !busy_out) busy_bad++;
      else if (done_cyc >= 0 && busy_out) busy_bad++;
      if (done_cyc >= 0 && c >= done_cyc + 2) begin timed_out = 0; break; end
      start_in       = (c == restart_at);
      static_mask_in = (c == restart_at) ? '1 : mask;
      if (hold && (!chk.pair_valid_out || int'(chk.pair_i_out) != hi || int'(chk.pair_j_out) != hj))
        stab_bad++;
      if (chk.pair_valid_out && outst >= MAXO) over_bad++;
      rdy = ($urandom_range(99) < rdy_pct);
      chk.pair_ready_in = rdy;
      if (pq_due.size() > 0 && pq_due[0] <= c + 1) begin
        ri = pq_i.pop_front(); rj = pq_j.pop_front(); void'(pq_due.pop_front());
        chk.res_valid_in = 1'b1; chk.res_hit_in = hit_en[ri][rj]; chk.res_time_in = hit_t[ri][rj];
        outst--;
      end else begin
        chk.res_valid_in = 1'b0; chk.res_hit_in = 1'b0; chk.res_time_in = '0;
      end
      if (chk.pair_valid_out && rdy) begin
        hi = int'(chk.pair_i_out); hj = int'(chk.pair_j_out);
        iss_vec = {iss_vec[8*NP-9:0], 8'((hi << 4) | hj)};
        iss_n++;
        pq_i.push_back(hi); pq_j.push_back(hj); pq_due.push_back(c + 1 + lat);
        outst++; hold = 0;
      end else if (chk.pair_valid_out) begin
        hold = 1; hi = int'(chk.pair_i_out); hj = int'(chk.pair_j_out);
      end else hold = 0;
      if (outst > max_out) max_out = outst;
      @(negedge sys_clk);
    end
    start_in = 1'b0; static_mask_in = mask;
    chk.pair_ready_in = 1'b0; chk.res_valid_in = 1'b0; chk.res_hit_in = 1'b0; chk.res_time_in = '0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    total++;
    if (out_snap() !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", out_snap()); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    total++;
    if (out_snap() !== '0) begin bad++; $display("FAIL idle_outputs got=%h want=0", out_snap()); end
  endtask

  task automatic test_basic();
    clear_hits();
    ref_model('0, 32'h800);
    run_pass('0, 32'h800, 1, 100, -1, 0);
    total++;
    if (timed_out) begin bad++; $display("FAIL basic_timeout got=timeout want=done"); end
    total++;
    if (iss_n !== exp_n || iss_vec !== exp_vec)
      begin bad++; $display("FAIL basic_order got n=%0d %h want n=%0d %h", iss_n, iss_vec, exp_n, exp_vec); end
    total++;
    if (n_done !== 1 || busy_bad !== 0)
      begin bad++; $display("FAIL basic_done got done=%0d busybad=%0d want 1/0", n_done, busy_bad); end
    total++;
    if (res_obs() !== {1'b0, 32'h800, 3'd0, 3'd0, 1'b0})
      begin bad++; $display("FAIL basic_result got=%h want=%h", res_obs(), {1'b0, 32'h800, 3'd0, 3'd0, 1'b0}); end
  endtask

  task automatic test_hits();
    clear_hits();
    hit_en[2][5] = 1; hit_t[2][5] = 32'h300;
    hit_en[1][3] = 1; hit_t[1][3] = 32'h500;
    hit_en[4][6] = 1; hit_t[4][6] = 32'h300;
    run_pass('0, 32'h800, 1, 100, -1, 0);
    total++;
    if (timed_out || res_obs() !== {1'b1, 32'h300, 3'd2, 3'd5, 1'b0})
      begin bad++; $display("FAIL hits_tie got=%h want=%h", res_obs(), {1'b1, 32'h300, 3'd2, 3'd5, 1'b0}); end
  endtask

  task automatic test_mask();
    clear_hits();
    hit_en[0][2] = 1; hit_t[0][2] = 32'h10;
    hit_en[3][7] = 1; hit_t[3][7] = 32'h200;
    ref_model(8'b0000_0111, 32'h800);
    run_pass(8'b0000_0111, 32'h800, 2, 100, -1, 0);
    total++;
    if (iss_n !== 25 || iss_vec !== exp_vec)
      begin bad++; $display("FAIL mask_order got n=%0d %h want n=25 %h", iss_n, iss_vec, exp_vec); end
    total++;
    if (timed_out || n_done !== 1 || res_obs() !== {1'b1, 32'h200, 3'd3, 3'd7, 1'b0})
      begin bad++; $display("FAIL mask_result got done=%0d %h want done=1 %h", n_done, res_obs(), {1'b1, 32'h200, 3'd3, 3'd7, 1'b0}); end
  endtask

  task automatic test_all_static();
    clear_hits();
    run_pass('1, 32'h123, 1, 100, -1, 0);
    total++;
    if (iss_n !== 0 || done_cyc !== NP + 2 || n_done !== 1)
      begin bad++; $display("FAIL all_static got n=%0d lat=%0d done=%0d want 0/%0d/1", iss_n, done_cyc, n_done, NP + 2); end
    total++;
    if (res_obs() !== {1'b0, 32'h123, 3'd0, 3'd0, 1'b0})
      begin bad++; $display("FAIL all_static_result got=%h want=%h", res_obs(), {1'b0, 32'h123, 3'd0, 3'd0, 1'b0}); end
  endtask

  task automatic test_backpressure();
    clear_hits();
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++) begin
        hit_en[i][j] = 1; hit_t[i][j] = TW'(32'h700 - 32'((i * N + j) * 16)) ^ TW'($urandom_range(3) * 32'h100);
      end
    ref_model('0, 32'h800);
    run_pass('0, 32'h800, 6, 50, -1, 0);
    total++;
    if (max_out > MAXO || over_bad !== 0)
      begin bad++; $display("FAIL bp_outstanding got max=%0d over=%0d want <=%0d/0", max_out, over_bad, MAXO); end
    total++;
    if (stab_bad !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stab_bad); end
    total++;
    if (iss_n !== NP || iss_vec !== exp_vec)
      begin bad++; $display("FAIL bp_order got n=%0d want n=%0d", iss_n, NP); end
    total++;
    if (timed_out || n_done !== 1 || res_obs() !== exp_res)
      begin bad++; $display("FAIL bp_result got done=%0d %h want done=1 %h", n_done, res_obs(), exp_res); end
  endtask

  task automatic test_left_time();
    clear_hits();
    hit_en[0][7] = 1; hit_t[0][7] = 32'h400;
    run_pass('0, 32'h400, 3, 100, -1, 0);
    total++;
    if (timed_out || res_obs() !== {1'b0, 32'h400, 3'd0, 3'd0, 1'b0})
      begin bad++; $display("FAIL left_time got=%h want=%h", res_obs(), {1'b0, 32'h400, 3'd0, 3'd0, 1'b0}); end
    @(negedge sys_clk);
    chk.res_valid_in = 1'b1; chk.res_hit_in = 1'b1; chk.res_time_in = '0;
    @(negedge sys_clk);
    chk.res_valid_in = 1'b0; chk.res_hit_in = 1'b0;
    @(negedge sys_clk);
    total++;
    if (res_obs() !== {1'b0, 32'h400, 3'd0, 3'd0, 1'b1})
      begin bad++; $display("FAIL stray_err got=%h want=%h", res_obs(), {1'b0, 32'h400, 3'd0, 3'd0, 1'b1}); end
  endtask

  task automatic test_start_ignored();
    clear_hits();
    hit_en[1][2] = 1; hit_t[1][2] = 32'h200;
    ref_model('0, 32'h800);
    run_pass('0, 32'h800, 3, 70, 5, 0);
    total++;
    if (iss_n !== NP || iss_vec !== exp_vec || n_done !== 1)
      begin bad++; $display("FAIL restart_ignored got n=%0d done=%0d want n=%0d done=1", iss_n, n_done, NP); end
    total++;
    if (timed_out || res_obs() !== exp_res)
      begin bad++; $display("FAIL restart_result got=%h want=%h", res_obs(), exp_res); end
  endtask

  task automatic test_abort();
    clear_hits();
    hit_en[3][4] = 1; hit_t[3][4] = 32'h100;
    run_pass('0, 32'h800, 6, 100, -1, 1);
    total++;
    if (timed_out || abort_snap !== '0)
      begin bad++; $display("FAIL abort_outputs got=%h want=0", abort_snap); end
    total++;
    if (n_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", n_done); end
    ref_model('0, 32'h800);
    run_pass('0, 32'h800, 2, 100, -1, 0);
    total++;
    if (timed_out || iss_vec !== exp_vec || n_done !== 1 || res_obs() !== exp_res)
      begin bad++; $display("FAIL after_abort got done=%0d %h want done=1 %h", n_done, res_obs(), exp_res); end
  endtask

  task automatic test_random();
    logic [N-1:0]  m;
    logic [TW-1:0] lt;
    for (int k = 0; k < 5; k++) begin
      clear_hits();
      m  = N'($urandom & $urandom);
      lt = TW'($urandom_range(3, 9) * 32'h100);
      for (int i = 0; i < N; i++)
        for (int j = i + 1; j < N; j++) begin
          hit_en[i][j] = ($urandom_range(99) < 25);
          hit_t[i][j]  = TW'($urandom_range(0, 9) * 32'h100);
        end
      ref_model(m, lt);
      run_pass(m, lt, $urandom_range(1, 7), $urandom_range(30, 100), -1, 0);
      total++;
      if (iss_n !== exp_n || iss_vec !== exp_vec || over_bad !== 0 || stab_bad !== 0)
        begin bad++; $display("FAIL rand%0d_issue got n=%0d over=%0d stab=%0d want n=%0d", k, iss_n, over_bad, stab_bad, exp_n); end
      total++;
      if (timed_out || n_done !== 1 || busy_bad !== 0 || res_obs() !== exp_res)
        begin bad++; $display("FAIL rand%0d_result got done=%0d %h want done=1 %h", k, n_done, res_obs(), exp_res); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    sys_rst_n = 1'b0; start_in = 1'b0; static_mask_in = '0; left_time_in = '0;
    chk.pair_ready_in = 1'b0; chk.res_valid_in = 1'b0; chk.res_hit_in = 1'b0; chk.res_time_in = '0;
    clear_hits();
    test_reset();
    test_basic();
    test_hits();
    test_mask();
    test_all_static();
    test_backpressure();
    test_left_time();
    test_start_ignored();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
